puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
// Drives the arbiter-PUF mux chain and collects its response. Steps a challenge LFSR, fires a launch pulse
// into the chain, samples the arbiter bit after a settle window, and repeats each challenge for a majority
// vote. Packs the voted bits into a response word and hands it out over a valid/ready handshake.
// Sits directly around the delay line: opulse/ochallenge feed the chain; iarb is the arbiter flop output.
// PARAMETERS
// C_LENGTH     32  challenge width = number of mux stages; legal values are 8/16/32/64 (elaboration error otherwise)
// C_RESP_BITS  32  voted response bits per request
// C_REPEAT     5   evaluations per challenge; must be odd and >=1
// C_SETTLE     8   cycles opulse is held high per evaluation; must be >=3
// C_RECOVER    4   cycles opulse is held low after each evaluation; must be >=1
// PORTS
// iclk           in   1              system clock
// irst_n         in   1              asynchronous active-low reset
// istart         in   1              request pulse; accepted only in IDLE with ovalid=0
// iseed          in   C_LENGTH       first challenge; a seed of 0 is replaced by 1
// iarb           in   1              arbiter response bit, asynchronous to iclk
// opulse         out  1              launch pulse to the chain (registered)
// ochallenge     out  C_LENGTH       mux select vector to the chain (registered)
// obusy          out  1              request in progress
// oresp          out  C_RESP_BITS    voted response word; bit k = vote for the k-th challenge
// ovalid         out  1              oresp is valid
// iready         in   1              consumer accepts oresp
// ounstable_cnt  out  $clog2(C_RESP_BITS+1)  count of non-unanimous challenges in this request
// BEHAVIOUR
// - Reset (async): opulse=0, ochallenge=0, obusy=0, oresp=0, ovalid=0, ounstable_cnt=0, FSM=IDLE.
//   Reset mid-request aborts the request, and opulse drops immediately.
// - iarb passes through a 2-flop synchronizer. The sampled value is stage 2 on the last high cycle of opulse.
// - FSM states: IDLE -> LOAD -> LAUNCH -> RECOVER -> (LAUNCH | VOTE) -> (LAUNCH | DONE) -> IDLE.
// - IDLE: when istart=1 and ovalid=0, accept the request. Set obusy=1, clear ounstable_cnt, clear the ones counter.
//   istart is ignored in all other states and while ovalid=1.
// - LOAD (1 cycle): ochallenge <= (iseed==0) ? 1 : iseed.
// - LAUNCH: opulse=1 for exactly C_SETTLE cycles, then capture the sample; ones += sample.
// - RECOVER: opulse=0 for C_RECOVER cycles. After the C_REPEAT-th evaluation go to VOTE, else go to LAUNCH.
// - VOTE (1 cycle):
//   - vote = (ones > C_REPEAT/2); write vote into oresp[bit_idx].
//   - If 0<ones<C_REPEAT, ounstable_cnt += 1 (saturating). Clear ones.
//   - Advance the LFSR one step.
//   - If bit_idx==C_RESP_BITS-1 go to DONE, else go to LAUNCH.
// - ochallenge changes only in LOAD/VOTE, when opulse=0. It never changes while opulse=1.
// - LFSR: Galois, shift right, XOR the tap mask when the LSB is 1.
//   Tap masks come from the package: 8:0xB8, 16:0xB400, 32:0x80200003, 64:0xD800000000000000.
// - DONE: ovalid=1 and obusy=0. oresp and ounstable_cnt are held stable until iready=1.
//   ovalid drops on the next edge after the cycle with ovalid&&iready; the FSM returns to IDLE.
//   iready while ovalid=0 has no effect.
// - Latency from the istart-accept edge to ovalid=1:
//   1 + C_RESP_BITS*(C_REPEAT*(C_SETTLE+C_RECOVER)+1) cycles.
// - bit_idx width is $clog2(C_RESP_BITS); the repeat counter width is $clog2(C_REPEAT+1).
//   All counters reset to 0 at accept.
// STRUCTURE
// - Package puf_pkg: FSM state enum, LFSR tap-mask function indexed by C_LENGTH, parameter legality checks.
// - Sub-module puf_lfsr (load/step/state, width C_LENGTH). FSM, synchronizer, vote and packing live in this module.
// TESTING (C_LENGTH=8, C_RESP_BITS=4, C_REPEAT=3, C_SETTLE=4, C_RECOVER=2; latency = 77 cycles)
// 1. iarb=1, iseed=0x5A, istart pulse -> ovalid at +77 cycles, oresp=4'hF, ounstable_cnt=0, first ochallenge=0x5A.
// 2. iarb=0, iseed=0x00 -> first ochallenge=0x01, then 0xB8, 0x5C, 0x2E; oresp=4'h0, ounstable_cnt=0.
// 3. iarb pattern 1,1,0 per challenge (changed during RECOVER) -> oresp=4'hF, ounstable_cnt=4.
//    Pattern 0,1,0 -> oresp=4'h0, ounstable_cnt=4.
// 4. Hold iready=0 for 10 cycles after ovalid, pulse istart meanwhile:
//    - oresp and ovalid stay stable; no new request starts.
//    - iready=1 -> ovalid=0 next edge, FSM in IDLE.
// 5. irst_n low during the 2nd LAUNCH -> opulse, obusy, ovalid go to 0 without a clock edge.
//    Re-run scenario 1 after release -> identical result.
// 6. Monitor on all runs:
//    - ochallenge matches the LFSR model and is stable whenever opulse=1.
//    - opulse high-time is 4 cycles and low-time is >=2 cycles.

Source files
------------

// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared FSM states, LFSR tap masks and parameter checks for the PUF evaluator
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_RECOVER,
    ST_VOTE,
    ST_DONE
  } puf_state_e;

  function automatic logic [63:0] lfsr_taps(input int len);
    case (len)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic params_legal(input int len, input int rep, input int settle,
                                        input int recover);
    return (len == 8 || len == 16 || len == 32 || len == 64) &&
           (rep >= 1) && (rep % 2 == 1) && (settle >= 3) && (recover >= 1);
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// rtl/puf_lfsr.sv - Galois right-shift challenge LFSR with synchronous load and step
module puf_lfsr #(
  parameter int              W    = 32,
  parameter logic [W-1:0]    TAPS = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         step_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (step_i) begin
      state_q <= {1'b0, state_q[W-1:1]} ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - arbiter-PUF launch/sample/vote controller
// Repeats each challenge C_REPEAT times, majority-votes the arbiter bit, packs votes into oresp.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int C_LENGTH    = 32,
  parameter int C_RESP_BITS = 32,
  parameter int C_REPEAT    = 5,
  parameter int C_SETTLE    = 8,
  parameter int C_RECOVER   = 4
) (
  input  logic                             iclk,
  input  logic                             irst_n,
  input  logic                             istart,
  input  logic [C_LENGTH-1:0]              iseed,
  input  logic                             iarb,
  output logic                             opulse,
  output logic [C_LENGTH-1:0]              ochallenge,
  output logic                             obusy,
  output logic [C_RESP_BITS-1:0]           oresp,
  output logic                             ovalid,
  input  logic                             iready,
  output logic [$clog2(C_RESP_BITS+1)-1:0] ounstable_cnt
);

  localparam int IDX_W   = (C_RESP_BITS > 1) ? $clog2(C_RESP_BITS) : 1;
  localparam int REP_W   = $clog2(C_REPEAT + 1);
  localparam int CYC_MAX = (C_SETTLE > C_RECOVER) ? C_SETTLE : C_RECOVER;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int UNS_W   = $clog2(C_RESP_BITS + 1);
  localparam logic [C_LENGTH-1:0] TAPS = C_LENGTH'(lfsr_taps(C_LENGTH));

  if (!params_legal(C_LENGTH, C_REPEAT, C_SETTLE, C_RECOVER)) begin : g_bad_params
    $error("puf_eval_ctrl: illegal parameter combination");
  end

  puf_state_e       state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] ones_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic             sync1_q, sync2_q;
  logic [C_LENGTH-1:0] seed_d;

  assign seed_d = (iseed == '0) ? C_LENGTH'(1) : iseed;

  puf_lfsr #(
    .W    (C_LENGTH),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk_i   (iclk),
    .rst_ni  (irst_n),
    .load_i  (state_q == ST_LOAD),
    .seed_i  (seed_d),
    .step_i  (state_q == ST_VOTE),
    .state_o (ochallenge)
  );

  // opulse rises on the same edge the new challenge lands, so the chain never sees a change mid-pulse.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      rep_q         <= '0;
      ones_q        <= '0;
      bit_idx_q     <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      opulse        <= 1'b0;
      obusy         <= 1'b0;
      oresp         <= '0;
      ovalid        <= 1'b0;
      ounstable_cnt <= '0;
    end else begin
      sync1_q <= iarb;
      sync2_q <= sync1_q;
      case (state_q)
        ST_IDLE: begin
          if (istart && !ovalid) begin
            state_q       <= ST_LOAD;
            obusy         <= 1'b1;
            ounstable_cnt <= '0;
            ones_q        <= '0;
            rep_q         <= '0;
            bit_idx_q     <= '0;
            cyc_q         <= '0;
          end
        end
        ST_LOAD: begin
          state_q <= ST_LAUNCH;
          opulse  <= 1'b1;
          cyc_q   <= '0;
        end
        ST_LAUNCH: begin
          if (cyc_q == CYC_W'(C_SETTLE - 1)) begin
            opulse  <= 1'b0;
            ones_q  <= ones_q + REP_W'(sync2_q);
            rep_q   <= rep_q + REP_W'(1);
            cyc_q   <= '0;
            state_q <= ST_RECOVER;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        ST_RECOVER: begin
          if (cyc_q == CYC_W'(C_RECOVER - 1)) begin
            cyc_q <= '0;
            if (rep_q == REP_W'(C_REPEAT)) begin
              state_q <= ST_VOTE;
            end else begin
              state_q <= ST_LAUNCH;
              opulse  <= 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        ST_VOTE: begin
          oresp[bit_idx_q] <= (ones_q > REP_W'(C_REPEAT / 2));
          if (ones_q != '0 && ones_q != REP_W'(C_REPEAT) && ounstable_cnt != {UNS_W{1'b1}}) begin
            ounstable_cnt <= ounstable_cnt + UNS_W'(1);
          end
          ones_q <= '0;
          rep_q  <= '0;
          if (bit_idx_q == IDX_W'(C_RESP_BITS - 1)) begin
            state_q <= ST_DONE;
            ovalid  <= 1'b1;
            obusy   <= 1'b0;
          end else begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            state_q   <= ST_LAUNCH;
            opulse    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (iready) begin
            ovalid  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - self-checking bench for puf_eval_ctrl
module tb_puf_eval_ctrl;

  localparam int LEN = 8, RB = 4, REP = 3, SET = 4, REC = 2;
  localparam int LAT = 1 + RB * (REP * (SET + REC) + 1);
  localparam int NEV = RB * REP;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           istart;
  logic [LEN-1:0] iseed;
  logic           iarb = 1'b0;
  logic           iready;
  logic           opulse, obusy, ovalid;
  logic [LEN-1:0] ochallenge;
  logic [RB-1:0]  oresp;
  logic [2:0]     ounstable_cnt;

  always #5 clk = ~clk;

  puf_eval_ctrl #(
    .C_LENGTH(LEN), .C_RESP_BITS(RB), .C_REPEAT(REP), .C_SETTLE(SET), .C_RECOVER(REC)
  ) dut (
    .iclk(clk), .irst_n(rst_n), .istart(istart), .iseed(iseed), .iarb(iarb),
    .opulse(opulse), .ochallenge(ochallenge), .obusy(obusy), .oresp(oresp),
    .ovalid(ovalid), .iready(iready), .ounstable_cnt(ounstable_cnt)
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LEN-1:0] lfsr_next(input logic [LEN-1:0] s);
    int v;
    v = int'(s) / 2;
    if (s % 2 == 1) v = v ^ 'hB8;
    return LEN'(v);
  endfunction

  function automatic void model(input logic [NEV-1:0] pat, output logic [RB-1:0] r, output int u);
    r = '0;
    u = 0;
    for (int k = 0; k < RB; k++) begin
      int ones = 0;
      for (int j = 0; j < REP; j++) ones += int'(pat[k*REP+j]);
      r[k] = (2 * ones > REP);
      if (ones != 0 && ones != REP) u++;
    end
  endfunction

  logic [NEV-1:0] arb_seq = '0;
  logic [LEN-1:0] mon_seed = '0;
  int             eval_cnt = 0;
  logic           prev_pulse = 1'b0, prev_busy = 1'b0;
  int             hi_cnt = 0, lo_cnt = 0;
  logic [LEN-1:0] exp_chal = '0;

  // Monitor: drives iarb per evaluation (changed only while the pulse is low) and checks pulse shape/challenges.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pulse = 1'b0;
      prev_busy  = 1'b0;
      hi_cnt     = 0;
    end else begin
      if (obusy && !prev_busy) begin
        eval_cnt = 0;
        lo_cnt   = REC;
        exp_chal = (mon_seed == '0) ? LEN'(1) : mon_seed;
        iarb     = arb_seq[0];
      end
      if (opulse && !prev_pulse) begin
        if (eval_cnt > 0 && eval_cnt % REP == 0) exp_chal = lfsr_next(exp_chal);
        check("pulse_low_time_ok", lo_cnt >= REC, 1);
        hi_cnt = 1;
      end else if (opulse) begin
        hi_cnt++;
      end
      if (opulse) check("challenge_during_pulse", ochallenge, exp_chal);
      if (!opulse && prev_pulse) begin
        check("pulse_high_time", hi_cnt, SET);
        eval_cnt++;
        lo_cnt = 1;
        if (eval_cnt < NEV) iarb = arb_seq[eval_cnt];
      end else if (!opulse) begin
        lo_cnt++;
      end
      prev_pulse = opulse;
      prev_busy  = obusy;
    end
  end

  task automatic run_req(input string tag, input logic [LEN-1:0] seed, input logic [NEV-1:0] pat,
                         input logic [RB-1:0] exp_resp, input int exp_uns,
                         input logic [LEN-1:0] exp_first, input bit early_ready, input int hold);
    int n;
    logic [RB-1:0] held;
    iseed    = seed;
    mon_seed = seed;
    arb_seq  = pat;
    iready   = early_ready;
    repeat (2) @(negedge clk);
    istart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    istart = 1'b0;
    check({tag, "_busy_after_accept"}, obusy, 1);
    n = 0;
    while (!ovalid && n < LAT + 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_first_challenge"}, ochallenge, exp_first);
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_oresp"}, oresp, exp_resp);
    check({tag, "_unstable_cnt"}, ounstable_cnt, exp_uns);
    check({tag, "_busy_in_done"}, obusy, 0);
    held = oresp;
    for (int i = 0; i < hold; i++) begin
      if (i == 3) istart = 1'b1;
      if (i == 5) istart = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, ovalid, 1);
      check({tag, "_hold_resp"}, oresp, held);
      check({tag, "_hold_not_busy"}, obusy, 0);
    end
    istart = 1'b0;
    iready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, ovalid, 0);
    iready = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_idle_after"}, {obusy, opulse, ovalid}, 3'b000);
  endtask

  typedef struct {
    logic [LEN-1:0] seed;
    logic [NEV-1:0] pat;
    logic [RB-1:0]  resp;
    int             uns;
    logic [LEN-1:0] first;
    int             hold;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{seed: 8'h5A, pat: 12'hFFF, resp: 4'hF, uns: 0, first: 8'h5A, hold: 10};
    vecs[1] = '{seed: 8'h00, pat: 12'h000, resp: 4'h0, uns: 0, first: 8'h01, hold: 0};
    vecs[2] = '{seed: 8'h33, pat: 12'h6DB, resp: 4'hF, uns: 4, first: 8'h33, hold: 0};
    vecs[3] = '{seed: 8'hC1, pat: 12'h492, resp: 4'h0, uns: 4, first: 8'hC1, hold: 0};

    rst_n = 1'b0; istart = 1'b0; iready = 1'b0; iseed = '0;
    #12;
    check("reset_outputs", {opulse, ochallenge, obusy, oresp, ovalid, ounstable_cnt}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_req($sformatf("vec%0d", i), vecs[i].seed, vecs[i].pat, vecs[i].resp, vecs[i].uns,
              vecs[i].first, 1'b0, vecs[i].hold);

    begin : reset_mid_request
      int n;
      iseed = 8'h5A; mon_seed = 8'h5A; arb_seq = 12'hFFF;
      repeat (2) @(negedge clk);
      istart = 1'b1;
      @(negedge clk);
      istart = 1'b0;
      n = 0;
      while (!(opulse && eval_cnt == 1) && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("reach_second_launch", opulse && eval_cnt == 1, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {opulse, obusy, ovalid, ochallenge}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_req("rerun_vec0", 8'h5A, 12'hFFF, 4'hF, 0, 8'h5A, 1'b0, 0);
    end

    for (int r = 0; r < 6; r++) begin
      logic [LEN-1:0] s;
      logic [NEV-1:0] p;
      logic [RB-1:0]  er;
      int             eu;
      s = (r == 0) ? '0 : LEN'($urandom_range(0, 255));
      p = NEV'($urandom);
      model(p, er, eu);
      run_req($sformatf("rand%0d", r), s, p, er, eu, (s == '0) ? LEN'(1) : s, r[0], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
